// File: rtl/register_file_writer_pkg.sv
// Shared types and constants for the 8-entry register file writer.
// Holds the default data width, register count and FSM state encoding.
package register_file_writer_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int NUM_REGS           = 8;
    localparam int ADDR_WIDTH         = 3;
    localparam int REM_WIDTH          = 4;

    // 2'b11 is unused and falls back to ST_IDLE in the next-state logic.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_BURST = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    function automatic logic [REM_WIDTH-1:0] beats_from_len(input logic [ADDR_WIDTH-1:0] len);
        return (len == '0) ? REM_WIDTH'(NUM_REGS) : {1'b0, len};
    endfunction

endpackage

// File: rtl/register_file_writer_if.sv
// Bus bundle between a register file writer and whoever drives its writes.
// Burst handshake: a beat transfers on a rising clk edge where burst_valid and burst_ready are both high.
interface register_file_writer_if #(
    parameter int DATA_WIDTH = register_file_writer_pkg::DEFAULT_DATA_WIDTH
);
    logic                  we;
    logic [2:0]            wAddr;
    logic [DATA_WIDTH-1:0] wData;
    logic                  burst_start;
    logic [2:0]            burst_addr;
    logic [2:0]            burst_len;
    logic                  burst_valid;
    logic [DATA_WIDTH-1:0] burst_data;
    logic                  burst_ready;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] from_reg0;
    logic [DATA_WIDTH-1:0] from_reg1;
    logic [DATA_WIDTH-1:0] from_reg2;
    logic [DATA_WIDTH-1:0] from_reg3;
    logic [DATA_WIDTH-1:0] from_reg4;
    logic [DATA_WIDTH-1:0] from_reg5;
    logic [DATA_WIDTH-1:0] from_reg6;
    logic [DATA_WIDTH-1:0] from_reg7;
    register_file_writer_pkg::state_t dbg_state;

    modport master (
        output we, wAddr, wData, burst_start, burst_addr, burst_len, burst_valid, burst_data,
        input  burst_ready, busy, done,
        input  from_reg0, from_reg1, from_reg2, from_reg3,
        input  from_reg4, from_reg5, from_reg6, from_reg7,
        input  dbg_state
    );

    modport slave (
        input  we, wAddr, wData, burst_start, burst_addr, burst_len, burst_valid, burst_data,
        output burst_ready, busy, done,
        output from_reg0, from_reg1, from_reg2, from_reg3,
        output from_reg4, from_reg5, from_reg6, from_reg7,
        output dbg_state
    );

endinterface

// File: rtl/register_file_writer_write_decoder.sv
// 3-to-8 one-hot write-enable decoder shared by the single-write and burst paths.
module write_decoder (
    input  logic [2:0] i_addr,
    input  logic       i_en,
    output logic [7:0] o_we
);

    always_comb begin
        o_we = '0;
        if (i_en) begin
            o_we[i_addr] = 1'b1;
        end
    end

endmodule

// File: rtl/register_file_writer.sv
// Write side of the 8-entry register file: single-cycle writes in IDLE and an
// auto-incrementing, wrap-around burst load; all registers drive the read mux directly.
module register_file_writer
    import register_file_writer_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    register_file_writer_if.slave  bus
);

    state_t                  r_state;
    state_t                  w_next_state;
    logic [ADDR_WIDTH-1:0]   r_ptr;
    logic [REM_WIDTH-1:0]    r_rem;
    logic [DATA_WIDTH-1:0]   r_regs [NUM_REGS];

    logic                    w_wr_en;
    logic [ADDR_WIDTH-1:0]   w_wr_addr;
    logic [DATA_WIDTH-1:0]   w_wr_data;
    logic [NUM_REGS-1:0]     w_we_onehot;
    logic                    w_burst_latch;
    logic                    w_beat_accept;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // burst_start has priority over we in IDLE; the write mux follows the active path.
    always_comb begin
        w_next_state  = r_state;
        w_wr_en       = 1'b0;
        w_wr_addr     = bus.wAddr;
        w_wr_data     = bus.wData;
        w_burst_latch = 1'b0;
        w_beat_accept = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.burst_start) begin
                    w_burst_latch = 1'b1;
                    w_next_state  = ST_BURST;
                end else if (bus.we) begin
                    w_wr_en = 1'b1;
                end
            end
            ST_BURST: begin
                w_wr_addr = r_ptr;
                w_wr_data = bus.burst_data;
                if (bus.burst_valid) begin
                    w_wr_en       = 1'b1;
                    w_beat_accept = 1'b1;
                    if (r_rem == REM_WIDTH'(1)) begin
                        w_next_state = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Status outputs depend on the state register alone.
    always_comb begin
        bus.burst_ready = 1'b0;
        bus.busy        = 1'b0;
        bus.done        = 1'b0;
        case (r_state)
            ST_BURST: begin
                bus.burst_ready = 1'b1;
                bus.busy        = 1'b1;
            end
            ST_DONE: begin
                bus.busy = 1'b1;
                bus.done = 1'b1;
            end
            default: begin
                bus.burst_ready = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr <= '0;
            r_rem <= '0;
        end else if (w_burst_latch) begin
            r_ptr <= bus.burst_addr;
            r_rem <= beats_from_len(bus.burst_len);
        end else if (w_beat_accept) begin
            r_ptr <= r_ptr + ADDR_WIDTH'(1);
            r_rem <= r_rem - REM_WIDTH'(1);
        end
    end

    write_decoder u_write_decoder (
        .i_addr (w_wr_addr),
        .i_en   (w_wr_en),
        .o_we   (w_we_onehot)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_we_onehot[i]) begin
                    r_regs[i] <= w_wr_data;
                end
            end
        end
    end

    assign bus.from_reg0 = r_regs[0];
    assign bus.from_reg1 = r_regs[1];
    assign bus.from_reg2 = r_regs[2];
    assign bus.from_reg3 = r_regs[3];
    assign bus.from_reg4 = r_regs[4];
    assign bus.from_reg5 = r_regs[5];
    assign bus.from_reg6 = r_regs[6];
    assign bus.from_reg7 = r_regs[7];
    assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_register_file_writer.sv
// Self-checking bench for register_file_writer: directed scenarios plus random
// single writes and bursts against an array/queue model of the register file.
module tb_register_file_writer;
    import register_file_writer_pkg::*;

    localparam int DW = 32;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    register_file_writer_if #(.DATA_WIDTH(DW)) bus ();

    register_file_writer #(.DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] exp_regs [8];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] obs_regs [8];

    assign obs_regs[0] = bus.from_reg0;
    assign obs_regs[1] = bus.from_reg1;
    assign obs_regs[2] = bus.from_reg2;
    assign obs_regs[3] = bus.from_reg3;
    assign obs_regs[4] = bus.from_reg4;
    assign obs_regs[5] = bus.from_reg5;
    assign obs_regs[6] = bus.from_reg6;
    assign obs_regs[7] = bus.from_reg7;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s_reg%0d", tag, i), obs_regs[i], exp_regs[i]);
        end
    endtask

    task automatic check_status(input string tag, input bit busy, input bit ready, input bit done,
                                input logic [1:0] st);
        check({tag, "_busy"},  DW'(bus.busy),        DW'(busy));
        check({tag, "_ready"}, DW'(bus.burst_ready), DW'(ready));
        check({tag, "_done"},  DW'(bus.done),        DW'(done));
        check({tag, "_state"}, DW'(bus.dbg_state),   DW'(st));
    endtask

    task automatic clear_model();
        for (int i = 0; i < 8; i++) exp_regs[i] = '0;
        exp_q.delete();
    endtask

    task automatic single_write(input logic [2:0] addr, input logic [DW-1:0] data);
        bus.we    = 1'b1;
        bus.wAddr = addr;
        bus.wData = data;
        tick();
        bus.we = 1'b0;
        exp_regs[addr] = data;
        check_regs("single");
        check_status("single", 1'b0, 1'b0, 1'b0, 2'b00);
    endtask

    // mode 0: valid always high, 1: toggling 1,0,1,0..., 2: random
    task automatic run_burst(input logic [2:0] addr, input logic [2:0] len, input int mode,
                             input bit inject_we);
        int n;
        int acc;
        int cyc;
        bit valid;
        n = (len == 3'd0) ? 8 : int'(len);
        while (exp_q.size() < n) exp_q.push_back($urandom);
        bus.burst_start = 1'b1;
        bus.burst_addr  = addr;
        bus.burst_len   = len;
        if (inject_we) begin
            bus.we    = 1'b1;
            bus.wAddr = 3'd4;
            bus.wData = 32'hdeadbeef;
        end
        tick();
        bus.burst_start = 1'b0;
        check_regs("burst_start");
        check_status("burst_start", 1'b1, 1'b1, 1'b0, 2'b01);
        acc = 0;
        cyc = 0;
        while (acc < n && cyc < 64) begin
            case (mode)
                0:       valid = 1'b1;
                1:       valid = (cyc % 2 == 0);
                default: valid = 1'($urandom_range(0, 1));
            endcase
            bus.burst_valid = valid;
            bus.burst_data  = valid ? exp_q[0] : DW'($urandom);
            check("burst_ready_hi", DW'(bus.burst_ready), DW'(1));
            check("burst_done_lo",  DW'(bus.done),        DW'(0));
            tick();
            if (valid) begin
                exp_regs[3'(int'(addr) + acc)] = exp_q.pop_front();
                acc++;
            end
            cyc++;
            if (acc < n) check_regs("burst_beat");
        end
        bus.burst_valid = 1'b0;
        check("burst_beats_accepted", DW'(acc), DW'(n));
        check_regs("burst_end");
        check_status("burst_done", 1'b1, 1'b0, 1'b1, 2'b10);
        tick();
        bus.we = 1'b0;
        check_regs("after_done");
        check_status("after_done", 1'b0, 1'b0, 1'b0, 2'b00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DW-1:0] vals [8];
        vals = '{32'h12345678, 32'h13579bdf, 32'habcdef82, 32'h2385065d,
                 32'haaabbccd, 32'hffff222d, 32'h113239dc, 32'hccccffff};
        bus.we          = 1'b0;
        bus.wAddr       = '0;
        bus.wData       = '0;
        bus.burst_start = 1'b0;
        bus.burst_addr  = '0;
        bus.burst_len   = '0;
        bus.burst_valid = 1'b0;
        bus.burst_data  = '0;
        clear_model();

        repeat (2) tick();
        reset = 1'b0;
        tick();
        check_regs("por");
        check_status("por", 1'b0, 1'b0, 1'b0, 2'b00);

        // single writes of the listed values to 0..7
        for (int i = 0; i < 8; i++) single_write(3'(i), vals[i]);
        // last of back-to-back writes to one address wins
        single_write(3'd5, 32'h0badf00d);
        single_write(3'd5, 32'h600dcafe);

        // asynchronous reset observed before the next clock edge
        #2 reset = 1'b1;
        #1;
        clear_model();
        check_regs("async_rst");
        check_status("async_rst", 1'b0, 1'b0, 1'b0, 2'b00);
        #1 reset = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) single_write(3'(i), vals[i]);

        // burst from 6, three beats, valid held high, wraps to 0
        exp_q.push_back(32'h000000a1);
        exp_q.push_back(32'h000000b2);
        exp_q.push_back(32'h000000c3);
        run_burst(3'd6, 3'd3, 0, 1'b0);
        check("wrap_reg0", obs_regs[0], 32'h000000c3);

        // eight beats from 2 with toggling valid
        run_burst(3'd2, 3'd0, 1, 1'b0);

        // we during BURST and DONE, and we together with burst_start
        run_burst(3'd0, 3'd2, 0, 1'b1);
        check("we_ignored_reg4", obs_regs[4], exp_regs[4]);

        // random single writes and bursts
        for (int k = 0; k < 12; k++) begin
            single_write(3'($urandom_range(0, 7)), DW'($urandom));
        end
        for (int k = 0; k < 6; k++) begin
            run_burst(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 2, 1'($urandom_range(0, 1)));
        end

        // reset after 2 of 5 beats aborts the burst
        for (int k = 0; k < 5; k++) exp_q.push_back($urandom);
        bus.burst_start = 1'b1;
        bus.burst_addr  = 3'd3;
        bus.burst_len   = 3'd5;
        tick();
        bus.burst_start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            bus.burst_valid = 1'b1;
            bus.burst_data  = exp_q[0];
            tick();
            exp_regs[3'(3 + k)] = exp_q.pop_front();
        end
        check_regs("abort_pre");
        #2 reset = 1'b1;
        #1;
        clear_model();
        check_regs("abort_rst");
        check_status("abort_rst", 1'b0, 1'b0, 1'b0, 2'b00);
        #1 reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_status("abort_idle", 1'b0, 1'b0, 1'b0, 2'b00);
            check_regs("abort_idle");
        end
        bus.burst_valid = 1'b0;
        single_write(3'd1, 32'h5a5aa5a5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/register_file_writer.md
Name: register_file_writer

Overview:
Write side of the 8-entry register file. It holds the eight DATA_WIDTH-bit registers and drives them out as from_reg0..from_reg7, which feed the read mux directly. It accepts two kinds of write:
- single-cycle writes;
- a valid/ready burst that auto-increments the address with wrap-around, for bulk register loading.

Parameters:
DATA_WIDTH, 32, width of each register and of each write data bus
NUM_REGS, 8, register count; fixed, because the output port list is fixed at 8

Ports:
clk  input  1  rising-edge clock, sole clock
reset  input  1  asynchronous, active-high reset
we  input  1  single-write strobe; sampled only in IDLE
wAddr  input  3  single-write address
wData  input  DATA_WIDTH  single-write data
burst_start  input  1  start-burst request; sampled only in IDLE
burst_addr  input  3  first register of the burst
burst_len  input  3  beat count; 0 means 8 beats, 1..7 mean 1..7 beats
burst_valid  input  1  burst data beat present
burst_data  input  DATA_WIDTH  burst beat data
burst_ready  output  1  writer can accept a beat
busy  output  1  high in BURST and DONE
done  output  1  one-cycle pulse after the last burst beat is written
from_reg0..from_reg7  output  DATA_WIDTH each  registered contents of registers 0..7

Behaviour:
- Reset (asynchronous, active-high):
  - all from_regN = 0; state = IDLE; burst_ready = 0; busy = 0; done = 0;
  - internal pointer = 0; remaining count = 0.
- Reset asserted mid-burst aborts the burst immediately: registers are cleared and no done pulse is produced.
- Timing: every write is captured on a rising clk edge. The new value is visible on from_regN immediately after that edge (one-cycle latency). No combinational path exists from the write inputs to from_regN.
- State IDLE: burst_ready = 0, busy = 0.
  - burst_start = 1: latch ptr <= burst_addr and rem <= (burst_len == 0 ? 8 : burst_len); go to BURST. No register is written that cycle.
  - burst_start = 0 and we = 1: reg[wAddr] <= wData; stay in IDLE.
  - burst_start and we both high: burst_start wins and the single write is dropped.
  - Back-to-back single writes to the same address: the last one wins. Each edge writes exactly one register.
- State BURST: burst_ready = 1, busy = 1; we and burst_start are ignored.
  - burst_valid = 1: reg[ptr] <= burst_data; ptr <= ptr + 1 mod 8 (7 wraps to 0); rem <= rem - 1.
  - burst_valid = 0: hold; no timeout.
  - Beat accepted with rem == 1: go to DONE.
  - An 8-beat burst starting at any address writes all 8 registers exactly once.
- State DONE: burst_ready = 0, busy = 1, done = 1 for exactly this one cycle; we and burst_start are ignored; go to IDLE next edge.
- Outputs busy, burst_ready and done are decoded from the state register only (Moore); they are glitch-free relative to the inputs.
- Width rules:
  - ptr is 3 bits and wraps naturally.
  - rem is 4 bits so that it can hold 8.
  - Data is stored unmodified; there is no truncation or extension.

Decomposition:
- Shared package holds:
  - DATA_WIDTH default;
  - NUM_REGS = 8;
  - state encoding: IDLE = 2'b00, BURST = 2'b01, DONE = 2'b10, with 2'b11 recovering to IDLE.
- One sub-module, write_decoder: takes a 3-bit address plus an enable and produces an 8-bit one-hot write-enable. It is shared by the single-write and burst paths through a mux on address and data ahead of it.
- The eight registers are inline always blocks or a generate loop in the top.

Test Plan:
1. Reset with all from_regN previously nonzero -> every from_regN = 0, busy = 0, done = 0, burst_ready = 0, immediately and asynchronously (before the next clk edge).
2. Single writes of 12345678, 13579bdf, abcdef82, 2385065d, aaabbccd, ffff222d, 113239dc, ccccffff to addresses 0..7 -> each from_regN equals its value the edge after its write; the other registers are unchanged.
3. burst_start with burst_addr = 6, burst_len = 3, beats A1, B2, C3 with burst_valid held high -> reg6 = A1, reg7 = B2, reg0 = C3; done pulses one cycle the edge after the C3 beat; reg1..reg5 unchanged.
4. burst_len = 0 from addr 2 with burst_valid toggling 1,0,1,0... -> exactly 8 beats are accepted, only on valid cycles; all registers written; done is a single pulse.
5. we = 1 to addr 4 with data deadbeef during BURST, and we with burst_start in the same IDLE cycle -> reg4 is not written by we in either case; the burst proceeds normally.
6. Reset asserted after 2 of 5 beats -> all registers 0, state IDLE, done never pulses; a subsequent single write to addr 1 works normally.
